veggie_mp: RTL and testbench



---
 rtl/veggie_mp_pkg.sv | 18 +
 rtl/veggie_mp_vrf_bank.sv | 33 +++
 rtl/veggie_mp.sv | 150 +++++++++++++++
 tb/tb_veggie_mp.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/veggie_mp_pkg.sv
// rtl/veggie_mp_pkg.sv - shared types and constants for the veggie_mp vector register file
package veggie_mp_pkg;

  typedef enum logic [1:0] {IDLE, COLLECT, RESP} vrf_state_t;

  typedef enum logic [1:0] {
    OP_RS1  = 2'd0,
    OP_RS2  = 2'd1,
    OP_MASK = 2'd2
  } operand_sel_t;

  localparam int unsigned MASK_REG = 0;

  function automatic logic is_mask_reg(input int unsigned r);
    return r == MASK_REG;
  endfunction

endpackage

// File: rtl/veggie_mp_vrf_bank.sv
// rtl/veggie_mp_vrf_bank.sv - 1R1W synchronous-read data bank with per-element write strobes
module veggie_mp_vrf_bank #(
  parameter int ROWS   = 64,
  parameter int VLEN   = 32,
  parameter int ELEM_W = 16,
  parameter int AW     = $clog2(ROWS)
) (
  input  logic                     clk_i,
  input  logic                     ren_i,
  input  logic [AW-1:0]            raddr_i,
  input  logic                     wen_i,
  input  logic [AW-1:0]            waddr_i,
  input  logic [VLEN*ELEM_W-1:0]   wdata_i,
  input  logic [VLEN-1:0]          wstrb_i,
  output logic [VLEN*ELEM_W-1:0]   rdata_o
);

  logic [VLEN*ELEM_W-1:0] mem_q [ROWS];
  logic [VLEN*ELEM_W-1:0] rdata_q;

  // Contents are deliberately not reset; read data holds until the next read.
  always_ff @(posedge clk_i) begin
    if (ren_i) rdata_q <= mem_q[raddr_i];
    if (wen_i) begin
      for (int e = 0; e < VLEN; e++) begin
        if (wstrb_i[e]) mem_q[waddr_i][e*ELEM_W +: ELEM_W] <= wdata_i[e*ELEM_W +: ELEM_W];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/veggie_mp.sv
// rtl/veggie_mp.sv - banked vector register file with operand collection and conflict serialisation
module veggie_mp
  import veggie_mp_pkg::*;
#(
  parameter int BANK_COUNT = 4,
  parameter int VREG_COUNT = 256,
  parameter int VLEN       = 32,
  parameter int ELEM_W     = 16
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [$clog2(VREG_COUNT)-1:0] rs1,
  input  logic [$clog2(VREG_COUNT)-1:0] rs2,
  input  logic                          mask_en,
  input  logic                          wen,
  input  logic [$clog2(VREG_COUNT)-1:0] wd,
  input  logic [VLEN*ELEM_W-1:0]        wdata,
  input  logic [VLEN-1:0]               wstrb,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [VLEN*ELEM_W-1:0]        v1_data,
  output logic [VLEN*ELEM_W-1:0]        v2_data,
  output logic [VLEN-1:0]               vmask,
  output logic                          conflict
);

  localparam int RW        = $clog2(VREG_COUNT);
  localparam int BW        = $clog2(BANK_COUNT);
  localparam int AW        = RW - BW;
  localparam int ROWS      = VREG_COUNT / BANK_COUNT;
  localparam int DW        = VLEN * ELEM_W;
  localparam int CTRL_BANK = BANK_COUNT;

  typedef struct packed {
    logic            ren;
    logic [AW-1:0]   raddr;
    logic            wen;
    logic [AW-1:0]   waddr;
    logic [DW-1:0]   wdata;
    logic [VLEN-1:0] wstrb;
  } vrf_bank_req_t;

  vrf_state_t      state_q;
  logic [2:0]      pend_q, pend_d, cap_q, cur_pend, iss;
  logic [RW-1:0]   rs1_q, rs2_q, cur_rs1, cur_rs2;
  logic [DW-1:0]   v1_q, v2_q;
  logic [VLEN-1:0] vmask_q, mask_rd_q, ctrl_q;
  logic [BANK_COUNT:0] claim;
  logic [BW:0]     b1, b2;
  logic            accept, same, wr_mask;
  vrf_bank_req_t   breq  [BANK_COUNT];
  logic [DW-1:0]   rdata [BANK_COUNT];

  assign req_ready = (state_q == IDLE) || (state_q == RESP && out_ready);
  assign accept    = req_valid && req_ready;
  assign wr_mask   = wen && is_mask_reg(32'(wd));

  // The accepting cycle already issues, so it works from the live request fields.
  always_comb begin
    cur_rs1 = accept ? rs1 : rs1_q;
    cur_rs2 = accept ? rs2 : rs2_q;
    if (accept)                  cur_pend = {mask_en, 2'b11};
    else if (state_q == COLLECT) cur_pend = pend_q;
    else                         cur_pend = '0;
    same  = cur_rs1 == cur_rs2;
    b1    = {1'b0, cur_rs1[BW-1:0]};
    b2    = {1'b0, cur_rs2[BW-1:0]};
    claim = '0;
    if (wr_mask)  claim[CTRL_BANK] = 1'b1;
    else if (wen) claim[{1'b0, wd[BW-1:0]}] = 1'b1;

    iss = '0;
    iss[OP_RS1] = cur_pend[OP_RS1] && !claim[b1];
    if (same && cur_pend[OP_RS1]) iss[OP_RS2] = cur_pend[OP_RS2] && iss[OP_RS1];
    else iss[OP_RS2] = cur_pend[OP_RS2] && !claim[b2] && !(iss[OP_RS1] && b1 == b2);
    iss[OP_MASK] = cur_pend[OP_MASK] && !wr_mask;
    pend_d = cur_pend & ~iss;

    for (int b = 0; b < BANK_COUNT; b++) begin
      breq[b].ren   = (iss[OP_RS1] && b1 == (BW+1)'(b)) || (iss[OP_RS2] && b2 == (BW+1)'(b));
      breq[b].raddr = (iss[OP_RS1] && b1 == (BW+1)'(b)) ? cur_rs1[RW-1:BW] : cur_rs2[RW-1:BW];
      breq[b].wen   = wen && !wr_mask && wd[BW-1:0] == BW'(b);
      breq[b].waddr = wd[RW-1:BW];
      breq[b].wdata = wdata;
      breq[b].wstrb = wstrb;
    end
  end

  assign conflict = !RST && (|pend_d);

  for (genvar g = 0; g < BANK_COUNT; g++) begin : g_bank
    veggie_mp_vrf_bank #(.ROWS(ROWS), .VLEN(VLEN), .ELEM_W(ELEM_W)) u_bank (
      .clk_i   (CLK),
      .ren_i   (breq[g].ren),
      .raddr_i (breq[g].raddr),
      .wen_i   (breq[g].wen),
      .waddr_i (breq[g].waddr),
      .wdata_i (breq[g].wdata),
      .wstrb_i (breq[g].wstrb),
      .rdata_o (rdata[g])
    );
  end

  // Operands read last cycle bypass straight from the bank; afterwards the buffer holds them.
  assign out_valid = state_q == RESP;
  assign v1_data   = cap_q[OP_RS1]  ? rdata[rs1_q[BW-1:0]] : v1_q;
  assign v2_data   = cap_q[OP_RS2]  ? rdata[rs2_q[BW-1:0]] : v2_q;
  assign vmask     = cap_q[OP_MASK] ? mask_rd_q : vmask_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      pend_q    <= '0;
      cap_q     <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      v1_q      <= '0;
      v2_q      <= '0;
      vmask_q   <= '1;
      mask_rd_q <= '1;
      ctrl_q    <= '1;
    end else begin
      case (state_q)
        IDLE:    if (accept) state_q <= (|pend_d) ? COLLECT : RESP;
        COLLECT: if (~|pend_d) state_q <= RESP;
        RESP: begin
          if (accept)         state_q <= (|pend_d) ? COLLECT : RESP;
          else if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      pend_q  <= pend_d;
      cap_q   <= iss;
      v1_q    <= v1_data;
      v2_q    <= v2_data;
      vmask_q <= (accept && !mask_en) ? '1 : vmask;
      if (accept) begin
        rs1_q <= rs1;
        rs2_q <= rs2;
      end
      if (iss[OP_MASK]) mask_rd_q <= ctrl_q;
      for (int e = 0; e < VLEN; e++) begin
        if (wr_mask && wstrb[e]) ctrl_q[e] <= wdata[e*ELEM_W];
      end
    end
  end

endmodule

// File: tb/tb_veggie_mp.sv
// tb/tb_veggie_mp.sv - directed self-checking bench for veggie_mp
module tb_veggie_mp;

  localparam int DW = 512;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic          RST, req_valid, req_ready, mask_en, wen, out_valid, out_ready, conflict;
  logic [7:0]    rs1, rs2, wd;
  logic [DW-1:0] wdata, v1_data, v2_data, exp5;
  logic [31:0]   wstrb, vmask;
  int n_cmp;
  int n_fail;

  veggie_mp dut (
    .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_ready(req_ready),
    .rs1(rs1), .rs2(rs2), .mask_en(mask_en), .wen(wen), .wd(wd),
    .wdata(wdata), .wstrb(wstrb), .out_valid(out_valid), .out_ready(out_ready),
    .v1_data(v1_data), .v2_data(v2_data), .vmask(vmask), .conflict(conflict)
  );

  function automatic logic [DW-1:0] rep(input logic [15:0] x);
    return {32{x}};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_in();
    req_valid = 1'b0; mask_en = 1'b0; wen = 1'b0; wstrb = '0; out_ready = 1'b1;
  endtask

  task automatic do_write(input logic [7:0] r, input logic [DW-1:0] d, input logic [31:0] s);
    wen = 1'b1; wd = r; wdata = d; wstrb = s;
  endtask

  task automatic do_req(input logic [7:0] a, input logic [7:0] b, input logic m);
    req_valid = 1'b1; rs1 = a; rs2 = b; mask_en = m;
  endtask

  task automatic test_reset();
    RST = 1'b1; clear_in(); rs1 = '0; rs2 = '0; wd = '0; wdata = '0;
    tick(); tick(); settle();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (v1_data !== '0) begin n_fail++; $display("FAIL rst_v1: got %h want 0", v1_data); end
    n_cmp++; if (v2_data !== '0) begin n_fail++; $display("FAIL rst_v2: got %h want 0", v2_data); end
    n_cmp++; if (vmask !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL rst_vmask: got %h want ffffffff", vmask); end
    n_cmp++; if (conflict !== 1'b0) begin n_fail++; $display("FAIL rst_conflict: got %b want 0", conflict); end
    RST = 1'b0; settle();
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_basic();
    do_req(8'd1, 8'd2, 1'b1); settle();
    n_cmp++; if (conflict !== 1'b0) begin n_fail++; $display("FAIL basic_conflict: got %b want 0", conflict); end
    tick(); clear_in(); settle();
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b want 1", out_valid); end
    n_cmp++; if (vmask !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL basic_vmask: got %h want ffffffff", vmask); end
    tick(); settle();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_idle: got %b want 0", out_valid); end
  endtask

  task automatic test_setup_writes();
    do_write(8'd4, rep(16'h0004), '1); tick();
    do_write(8'd6, rep(16'h0006), '1); tick();
    do_write(8'd7, rep(16'h0007), '1); tick();
    do_write(8'd8, rep(16'h0008), '1); tick();
    do_write(8'd12, rep(16'h000C), '1); tick();
    clear_in();
  endtask

  task automatic test_write_read();
    do_write(8'd5, rep(16'h3C00), '1); tick(); clear_in();
    do_req(8'd5, 8'd6, 1'b0); settle();
    n_cmp++; if (conflict !== 1'b0) begin n_fail++; $display("FAIL wr_conflict: got %b want 0", conflict); end
    tick(); clear_in(); settle();
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL wr_valid: got %b want 1", out_valid); end
    n_cmp++; if (v1_data !== rep(16'h3C00)) begin n_fail++; $display("FAIL wr_v1: got %h want %h", v1_data, rep(16'h3C00)); end
    n_cmp++; if (v2_data !== rep(16'h0006)) begin n_fail++; $display("FAIL wr_v2: got %h want %h", v2_data, rep(16'h0006)); end
    n_cmp++; if (vmask !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wr_vmask: got %h want ffffffff", vmask); end
    tick();
  endtask

  task automatic test_same_bank();
    do_req(8'd4, 8'd8, 1'b0); settle();
    n_cmp++; if (conflict !== 1'b1) begin n_fail++; $display("FAIL sb_conflict_t: got %b want 1", conflict); end
    tick(); clear_in(); settle();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL sb_valid_t1: got %b want 0", out_valid); end
    n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL sb_ready_t1: got %b want 0", req_ready); end
    n_cmp++; if (conflict !== 1'b0) begin n_fail++; $display("FAIL sb_conflict_t1: got %b want 0", conflict); end
    tick(); settle();
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL sb_valid_t2: got %b want 1", out_valid); end
    n_cmp++; if (v1_data !== rep(16'h0004)) begin n_fail++; $display("FAIL sb_v1: got %h want %h", v1_data, rep(16'h0004)); end
    n_cmp++; if (v2_data !== rep(16'h0008)) begin n_fail++; $display("FAIL sb_v2: got %h want %h", v2_data, rep(16'h0008)); end
    tick();
  endtask

  task automatic test_coalesce();
    do_req(8'd7, 8'd7, 1'b0); settle();
    n_cmp++; if (conflict !== 1'b0) begin n_fail++; $display("FAIL co_conflict: got %b want 0", conflict); end
    tick(); clear_in(); settle();
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL co_valid: got %b want 1", out_valid); end
    n_cmp++; if (v1_data !== rep(16'h0007)) begin n_fail++; $display("FAIL co_v1: got %h want %h", v1_data, rep(16'h0007)); end
    n_cmp++; if (v2_data !== rep(16'h0007)) begin n_fail++; $display("FAIL co_v2: got %h want %h", v2_data, rep(16'h0007)); end
    tick();
  endtask

  task automatic test_hazard();
    exp5 = {{16{16'h3C00}}, {16{16'h4000}}};
    do_req(8'd5, 8'd6, 1'b0); do_write(8'd5, rep(16'h4000), 32'h0000_FFFF); settle();
    n_cmp++; if (conflict !== 1'b1) begin n_fail++; $display("FAIL hz_conflict: got %b want 1", conflict); end
    tick(); clear_in(); settle();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL hz_valid_t1: got %b want 0", out_valid); end
    tick(); settle();
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL hz_valid_t2: got %b want 1", out_valid); end
    n_cmp++; if (v1_data !== exp5) begin n_fail++; $display("FAIL hz_v1: got %h want %h", v1_data, exp5); end
    n_cmp++; if (v2_data !== rep(16'h0006)) begin n_fail++; $display("FAIL hz_v2: got %h want %h", v2_data, rep(16'h0006)); end
    tick();
  endtask

  task automatic test_mask_write();
    logic [DW-1:0] alt;
    for (int e = 0; e < 32; e++) alt[e*16 +: 16] = (e % 2 == 1) ? 16'h0001 : 16'h0000;
    do_req(8'd7, 8'd6, 1'b1); do_write(8'd0, alt, '1); settle();
    n_cmp++; if (conflict !== 1'b1) begin n_fail++; $display("FAIL mk_conflict: got %b want 1", conflict); end
    tick(); clear_in(); settle();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mk_valid_t1: got %b want 0", out_valid); end
    tick(); settle();
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mk_valid_t2: got %b want 1", out_valid); end
    n_cmp++; if (vmask !== 32'hAAAA_AAAA) begin n_fail++; $display("FAIL mk_vmask: got %h want aaaaaaaa", vmask); end
    n_cmp++; if (v1_data !== rep(16'h0007)) begin n_fail++; $display("FAIL mk_v1: got %h want %h", v1_data, rep(16'h0007)); end
    tick();
  endtask

  task automatic test_backpressure();
    do_req(8'd4, 8'd6, 1'b0); settle();
    tick(); clear_in();
    out_ready = 1'b0; do_req(8'd7, 8'd7, 1'b0); do_write(8'd4, rep(16'h1234), '1); settle();
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b want 1", i, out_valid); end
      n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b want 0", i, req_ready); end
      n_cmp++; if (v1_data !== rep(16'h0004)) begin n_fail++; $display("FAIL bp_v1[%0d]: got %h want %h", i, v1_data, rep(16'h0004)); end
      n_cmp++; if (v2_data !== rep(16'h0006)) begin n_fail++; $display("FAIL bp_v2[%0d]: got %h want %h", i, v2_data, rep(16'h0006)); end
      n_cmp++; if (vmask !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL bp_vmask[%0d]: got %h want ffffffff", i, vmask); end
      tick(); wen = 1'b0; settle();
    end
    clear_in(); settle();
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b want 1", req_ready); end
    tick(); settle();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_idle: got %b want 0", out_valid); end
  endtask

  task automatic test_max_latency();
    do_req(8'd8, 8'd12, 1'b0); do_write(8'd4, rep(16'h5555), '1); settle();
    n_cmp++; if (conflict !== 1'b1) begin n_fail++; $display("FAIL ml_conflict_t: got %b want 1", conflict); end
    tick(); clear_in(); settle();
    n_cmp++; if (conflict !== 1'b1) begin n_fail++; $display("FAIL ml_conflict_t1: got %b want 1", conflict); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ml_valid_t1: got %b want 0", out_valid); end
    tick(); settle();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ml_valid_t2: got %b want 0", out_valid); end
    n_cmp++; if (conflict !== 1'b0) begin n_fail++; $display("FAIL ml_conflict_t2: got %b want 0", conflict); end
    tick(); settle();
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL ml_valid_t3: got %b want 1", out_valid); end
    n_cmp++; if (v1_data !== rep(16'h0008)) begin n_fail++; $display("FAIL ml_v1: got %h want %h", v1_data, rep(16'h0008)); end
    n_cmp++; if (v2_data !== rep(16'h000C)) begin n_fail++; $display("FAIL ml_v2: got %h want %h", v2_data, rep(16'h000C)); end
    tick();
  endtask

  task automatic test_back_to_back();
    do_req(8'd5, 8'd6, 1'b0); settle();
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready0: got %b want 1", req_ready); end
    tick(); settle();
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid1: got %b want 1", out_valid); end
    n_cmp++; if (v1_data !== exp5) begin n_fail++; $display("FAIL b2b_v1_a: got %h want %h", v1_data, exp5); end
    do_req(8'd7, 8'd4, 1'b0); settle();
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready1: got %b want 1", req_ready); end
    tick(); settle();
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid2: got %b want 1", out_valid); end
    n_cmp++; if (v1_data !== rep(16'h0007)) begin n_fail++; $display("FAIL b2b_v1_b: got %h want %h", v1_data, rep(16'h0007)); end
    n_cmp++; if (v2_data !== rep(16'h5555)) begin n_fail++; $display("FAIL b2b_v2_b: got %h want %h", v2_data, rep(16'h5555)); end
    do_req(8'd12, 8'd5, 1'b0); settle();
    tick(); clear_in(); settle();
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid3: got %b want 1", out_valid); end
    n_cmp++; if (v1_data !== rep(16'h000C)) begin n_fail++; $display("FAIL b2b_v1_c: got %h want %h", v1_data, rep(16'h000C)); end
    n_cmp++; if (v2_data !== exp5) begin n_fail++; $display("FAIL b2b_v2_c: got %h want %h", v2_data, exp5); end
    tick(); settle();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    do_req(8'd4, 8'd8, 1'b1); settle();
    tick(); clear_in(); RST = 1'b1; settle();
    tick(); RST = 1'b0; settle();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rm_valid: got %b want 0", out_valid); end
    n_cmp++; if (vmask !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL rm_vmask: got %h want ffffffff", vmask); end
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rm_ready: got %b want 1", req_ready); end
    n_cmp++; if (conflict !== 1'b0) begin n_fail++; $display("FAIL rm_conflict: got %b want 0", conflict); end
    tick(); settle();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rm_dropped: got %b want 0", out_valid); end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    test_reset();
    test_basic();
    test_setup_writes();
    test_write_read();
    test_same_bank();
    test_coalesce();
    test_hazard();
    test_mask_write();
    test_backpressure();
    test_max_latency();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
